lifo_fifo_buffer: RTL and testbench

Parametrised buffer with valid/ready handshakes on both sides. A MODE parameter selects queue (FIFO) or stack (LIFO) ordering. Data is first-word-fall-through: the head (FIFO) or top (LIFO) entry is always presented on out_data. It is the successor to the fixed queue/stack pair and serves the labelling and flood-fill stages, which need backpressure, occupancy reporting and a single-cycle flush between frames.

---
 rtl/lifo_fifo_buffer_pkg.sv | 17 +
 rtl/lifo_fifo_buffer_sdp_ram.sv | 29 ++
 rtl/lifo_fifo_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_lifo_fifo_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_fifo_buffer_pkg.sv
// Shared constants and helpers for the FIFO/LIFO buffer.
// Configuration macro (top level): LIFO_FIFO_BUFFER_HWM_EN.
package lifo_fifo_buffer_pkg;

    localparam int MODE_FIFO = 0;
    localparam int MODE_LIFO = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/lifo_fifo_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, registered read port.
// A read of an address being written returns the old word.
module lifo_fifo_buffer_sdp_ram
    import lifo_fifo_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lifo_fifo_buffer.sv
// FWFT buffer with valid/ready on both sides, FIFO or LIFO by MODE.
// Optional high-water-mark output under LIFO_FIFO_BUFFER_HWM_EN.
module lifo_fifo_buffer
    import lifo_fifo_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int MODE       = MODE_FIFO,
    parameter int AF_LEVEL   = DEPTH - 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
`ifdef LIFO_FIFO_BUFFER_HWM_EN
    output logic [ADDR_WIDTH:0]   hwm,
`endif
    output logic                  almost_full,
    output logic                  empty
);

    localparam bit IS_LIFO = (MODE == MODE_LIFO);
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] C_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] C_ZERO  = '0;
    localparam logic [ADDR_WIDTH-1:0] P_LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_af;
    logic                  r_empty;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic                  r_refill;
    logic                  r_byp;
    logic [DATA_WIDTH-1:0] r_byp_data;

    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH:0]   w_count_nx;
    logic [ADDR_WIDTH-1:0] w_rd_nx;
    logic [ADDR_WIDTH-1:0] w_wr_nx;
    logic [DATA_WIDTH-1:0] w_out_nx;
    logic                  w_ov_nx;
    logic                  w_refill_nx;
    logic                  w_byp_nx;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [DATA_WIDTH-1:0] w_head;

    function automatic logic [ADDR_WIDTH-1:0] inc(
        input logic [ADDR_WIDTH-1:0] p
    );
        return (p == P_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;
    assign w_head = r_byp ? r_byp_data : w_rdata;

    always_comb begin
        w_count_nx  = r_count;
        w_rd_nx     = r_rd_ptr;
        w_wr_nx     = r_wr_ptr;
        w_out_nx    = r_out;
        w_ov_nx     = r_out_valid;
        w_refill_nx = 1'b0;
        w_we        = 1'b0;
        w_waddr     = r_wr_ptr;
        w_wdata     = in_data;
        w_raddr     = r_rd_ptr;
        if (w_push && !w_pop) begin
            w_count_nx = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nx = r_count - 1'b1;
        end
        if (IS_LIFO) begin
            // Stack: output register is the top, RAM[0..ptr-1] below it.
            w_raddr = r_wr_ptr - 1'b1;
            if (r_refill) begin
                w_ov_nx = 1'b1;
                if (w_push) begin
                    w_out_nx = in_data;
                    w_wr_nx  = r_wr_ptr + 1'b1;
                end else begin
                    w_out_nx = w_rdata;
                end
            end else if (w_push && w_pop) begin
                w_out_nx = in_data;
            end else if (w_push) begin
                w_out_nx = in_data;
                w_ov_nx  = 1'b1;
                if (r_out_valid) begin
                    w_we    = 1'b1;
                    w_wdata = r_out;
                    w_wr_nx = r_wr_ptr + 1'b1;
                end
            end else if (w_pop) begin
                w_ov_nx = 1'b0;
                if (r_count != C_ONE) begin
                    w_wr_nx     = r_wr_ptr - 1'b1;
                    w_refill_nx = 1'b1;
                end
            end
        end else begin
            if (w_push && (!r_out_valid || (w_pop && r_count == C_ONE))) begin
                w_out_nx = in_data;
            end else if (w_push) begin
                w_we    = 1'b1;
                w_wr_nx = inc(r_wr_ptr);
            end
            if (w_pop && r_count > C_ONE) begin
                w_out_nx = w_head;
                w_rd_nx  = inc(r_rd_ptr);
            end else if (w_pop && !w_push) begin
                w_ov_nx = 1'b0;
            end
            if (w_push) begin
                w_ov_nx = 1'b1;
            end
            w_raddr = w_rd_nx;
        end
    end

    // RAM returns old data on a collision, so remember the word just written.
    assign w_byp_nx = !IS_LIFO && w_we && (w_waddr == w_raddr);

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_af        <= 1'b0;
            r_empty     <= 1'b1;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_refill    <= 1'b0;
            r_byp       <= 1'b0;
            r_byp_data  <= '0;
        end else begin
            r_count     <= w_count_nx;
            r_in_ready  <= (w_count_nx != C_DEPTH);
            r_out_valid <= w_ov_nx;
            r_out       <= w_out_nx;
            r_af        <= (w_count_nx >= C_AF);
            r_empty     <= (w_count_nx == C_ZERO);
            r_rd_ptr    <= w_rd_nx;
            r_wr_ptr    <= w_wr_nx;
            r_refill    <= w_refill_nx;
            r_byp       <= w_byp_nx;
            r_byp_data  <= w_wdata;
        end
    end

    lifo_fifo_buffer_sdp_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_we && reset_n && !flush),
        .i_waddr(w_waddr),
        .i_wdata(w_wdata),
        .i_raddr(w_raddr),
        .o_rdata(w_rdata)
    );

`ifdef LIFO_FIFO_BUFFER_HWM_EN
    logic [ADDR_WIDTH:0] r_hwm;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hwm <= '0;
        end else if (!flush && w_count_nx > r_hwm) begin
            r_hwm <= w_count_nx;
        end
    end

    assign hwm = r_hwm;
`endif

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out;
    assign count       = r_count;
    assign almost_full = r_af;
    assign empty       = r_empty;

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Scoreboard bench: FIFO (DEPTH=5) and LIFO (DEPTH=8) instances.
module tb_lifo_fifo_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        f_flush, f_in_valid, f_in_ready, f_out_valid, f_out_ready;
    logic        f_af, f_empty;
    logic [31:0] f_in_data, f_out_data;
    logic [3:0]  f_count;
    logic        l_flush, l_in_valid, l_in_ready, l_out_valid, l_out_ready;
    logic        l_af, l_empty;
    logic [31:0] l_in_data, l_out_data;
    logic [3:0]  l_count;
`ifdef LIFO_FIFO_BUFFER_HWM_EN
    logic [3:0]  f_hwm, l_hwm;
`endif

    int checks   = 0;
    int failures = 0;
    logic [31:0] fq[$];
    logic [31:0] lq[$];

    lifo_fifo_buffer #(
        .ADDR_WIDTH(3), .DATA_WIDTH(32), .DEPTH(5), .MODE(0), .AF_LEVEL(3)
    ) u_fifo (
        .clk(clk), .reset_n(reset_n), .flush(f_flush),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
        .out_valid(f_out_valid), .out_ready(f_out_ready),
        .out_data(f_out_data), .count(f_count),
`ifdef LIFO_FIFO_BUFFER_HWM_EN
        .hwm(f_hwm),
`endif
        .almost_full(f_af), .empty(f_empty)
    );

    lifo_fifo_buffer #(
        .ADDR_WIDTH(3), .DATA_WIDTH(32), .DEPTH(8), .MODE(1), .AF_LEVEL(6)
    ) u_lifo (
        .clk(clk), .reset_n(reset_n), .flush(l_flush),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
        .out_valid(l_out_valid), .out_ready(l_out_ready),
        .out_data(l_out_data), .count(l_count),
`ifdef LIFO_FIFO_BUFFER_HWM_EN
        .hwm(l_hwm),
`endif
        .almost_full(l_af), .empty(l_empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fifo_run(input int pre, input int both,
                            input logic [31:0] base, input int exp_cnt);
        logic [31:0] d;
        d = base;
        f_out_ready = 1'b0;
        f_in_valid  = 1'b1;
        for (int i = 0; i < pre; i++) begin
            f_in_data = d;
            if (f_in_ready) begin
                fq.push_back(d);
                d++;
            end
            tick();
        end
        chk("fifo_pre_count", 32'(f_count), 32'(pre));
        f_out_ready = 1'b1;
        for (int i = 0; i < both; i++) begin
            f_in_data = d;
            if (f_in_ready) begin
                fq.push_back(d);
                d++;
            end
            tick();
        end
        chk("fifo_run_count", 32'(f_count), 32'(exp_cnt));
        f_in_valid = 1'b0;
        for (int i = 0; i < 12 && f_count != 0; i++) tick();
        f_out_ready = 1'b0;
        chk("fifo_run_empty", 32'(f_empty), 32'd1);
        chk("fifo_run_left", 32'(fq.size()), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        f_flush = 1'b0; f_in_valid = 1'b0; f_out_ready = 1'b0;
        l_flush = 1'b0; l_in_valid = 1'b0; l_out_ready = 1'b0;
        f_in_data = '0; l_in_data = '0;

        fork
            forever begin
                @(negedge clk);
                if (reset_n && f_out_valid && f_out_ready) begin
                    checks++;
                    if (fq.size() == 0) begin
                        failures++;
                        $display("FAIL fifo_extra_pop actual=%0h required=none",
                                 f_out_data);
                    end else if (f_out_data !== fq[0]) begin
                        failures++;
                        $display("FAIL fifo_pop actual=%0h required=%0h",
                                 f_out_data, fq[0]);
                        void'(fq.pop_front());
                    end else begin
                        void'(fq.pop_front());
                    end
                end
                if (reset_n && l_out_valid && l_out_ready) begin
                    checks++;
                    if (lq.size() == 0) begin
                        failures++;
                        $display("FAIL lifo_extra_pop actual=%0h required=none",
                                 l_out_data);
                    end else if (l_out_data !== lq[0]) begin
                        failures++;
                        $display("FAIL lifo_pop actual=%0h required=%0h",
                                 l_out_data, lq[0]);
                        void'(lq.pop_front());
                    end else begin
                        void'(lq.pop_front());
                    end
                end
            end
        join_none

        repeat (3) tick();
        reset_n = 1'b1;
        chk("rst_f_in_ready", 32'(f_in_ready), 32'd1);
        chk("rst_f_out_valid", 32'(f_out_valid), 32'd0);
        chk("rst_f_count", 32'(f_count), 32'd0);
        chk("rst_f_empty", 32'(f_empty), 32'd1);
        chk("rst_f_af", 32'(f_af), 32'd0);
        chk("rst_f_out_data", f_out_data, 32'd0);
        chk("rst_l_in_ready", 32'(l_in_ready), 32'd1);
        chk("rst_l_out_valid", 32'(l_out_valid), 32'd0);
        chk("rst_l_count", 32'(l_count), 32'd0);

        // FIFO fill to full then drain
        f_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            f_in_data = 32'hA + 32'(i);
            fq.push_back(f_in_data);
            tick();
            if (i == 0) begin
                chk("fifo_lat_valid", 32'(f_out_valid), 32'd1);
                chk("fifo_lat_data", f_out_data, 32'hA);
                chk("fifo_lat_empty", 32'(f_empty), 32'd0);
            end
        end
        chk("fifo_full_count", 32'(f_count), 32'd5);
        chk("fifo_full_in_ready", 32'(f_in_ready), 32'd0);
        chk("fifo_full_af", 32'(f_af), 32'd1);
        f_in_data = 32'hF;
        tick();
        chk("fifo_refused_count", 32'(f_count), 32'd5);
        chk("fifo_stall_data", f_out_data, 32'hA);
        f_in_valid  = 1'b0;
        f_out_ready = 1'b1;
        for (int i = 0; i < 12 && f_count != 0; i++) tick();
        f_out_ready = 1'b0;
        chk("fifo_drain_empty", 32'(f_empty), 32'd1);
        chk("fifo_drain_left", 32'(fq.size()), 32'd0);

        fifo_run(0, 20, 32'h100, 1);
        fifo_run(2, 8, 32'h200, 2);
        fifo_run(3, 9, 32'h300, 3);
        fifo_run(5, 6, 32'h400, 4);

        // LIFO push 1..5, pop with a refill bubble, swap top at count 3
        l_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            l_in_data = 32'(i + 1);
            tick();
            if (i == 0) begin
                chk("lifo_lat_valid", 32'(l_out_valid), 32'd1);
                chk("lifo_lat_data", l_out_data, 32'd1);
            end
        end
        chk("lifo_count5", 32'(l_count), 32'd5);
        chk("lifo_top5", l_out_data, 32'd5);
        chk("lifo_af5", 32'(l_af), 32'd0);
        l_in_valid = 1'b0;
        lq.push_back(32'd5);
        lq.push_back(32'd4);
        lq.push_back(32'd3);
        lq.push_back(32'h77);
        lq.push_back(32'd2);
        lq.push_back(32'd1);
        l_out_ready = 1'b1;
        tick();
        chk("lifo_bubble", 32'(l_out_valid), 32'd0);
        chk("lifo_count4", 32'(l_count), 32'd4);
        tick();
        chk("lifo_refill_valid", 32'(l_out_valid), 32'd1);
        chk("lifo_refill_data", l_out_data, 32'd4);
        tick();
        tick();
        chk("lifo_top3", l_out_data, 32'd3);
        l_in_valid = 1'b1;
        l_in_data  = 32'h77;
        tick();
        l_in_valid = 1'b0;
        chk("lifo_swap_data", l_out_data, 32'h77);
        chk("lifo_swap_count", 32'(l_count), 32'd3);
        chk("lifo_swap_valid", 32'(l_out_valid), 32'd1);
        for (int i = 0; i < 20 && l_count != 0; i++) tick();
        l_out_ready = 1'b0;
        chk("lifo_drain_empty", 32'(l_empty), 32'd1);
        chk("lifo_drain_left", 32'(lq.size()), 32'd0);

        // Flush with a concurrent push
        l_in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            l_in_data  = 32'h500 + 32'(i);
            f_in_valid = (i < 4);
            f_in_data  = 32'h600 + 32'(i);
            tick();
        end
        chk("lifo_count6", 32'(l_count), 32'd6);
        chk("lifo_af6", 32'(l_af), 32'd1);
        l_flush = 1'b1; l_in_data = 32'h999;
        f_flush = 1'b1; f_in_valid = 1'b1; f_in_data = 32'h999;
        tick();
        l_flush = 1'b0; l_in_valid = 1'b0;
        f_flush = 1'b0; f_in_valid = 1'b0;
        chk("flush_l_count", 32'(l_count), 32'd0);
        chk("flush_l_valid", 32'(l_out_valid), 32'd0);
        chk("flush_l_empty", 32'(l_empty), 32'd1);
        chk("flush_l_in_ready", 32'(l_in_ready), 32'd1);
        chk("flush_l_af", 32'(l_af), 32'd0);
        chk("flush_f_count", 32'(f_count), 32'd0);
        chk("flush_f_valid", 32'(f_out_valid), 32'd0);

        fifo_run(2, 3, 32'h700, 2);

`ifdef LIFO_FIFO_BUFFER_HWM_EN
        chk("hwm_fifo", 32'(f_hwm), 32'd5);
        chk("hwm_lifo", 32'(l_hwm), 32'd6);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
